// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter
// Shares the single vga_adapter pixel-write port between NREQ drawing engines.
// An engine is granted the port for a whole burst, so one sprite draw is never
// interleaved with another. While a burst is in progress, no other engine can
// take the port, even one with higher priority.
// Arbitration is fixed-priority: index 0 has the highest priority. There is one
// exception. An engine that has waited STARVE_LIMIT cycles or more is promoted
// ahead of the others.
// Pixels written to the VGA adapter are registered, with one cycle of latency.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   req[i]               engine i wants the port (held for the whole burst)
//   pix_valid/last[i]    engine i presents a pixel / the final pixel of a burst
//   pix_x/y/color        packed per-engine coordinates and colour (slice i)
//   gnt                  one-hot registered grant
//   vga_x/y/color/write  registered pixel write towards vga_adapter
//   owner, busy          index of the current grantee, and grant-held flag
//   drop_err             sticky: a non-granted engine presented a pixel
module vga_write_arbiter #(
  parameter int NREQ         = 4,
  parameter int XW           = 10,
  parameter int YW           = 9,
  parameter int CW           = 9,
  parameter int STARVE_LIMIT = 1024,
  parameter int WCW          = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          pix_valid,
  input  logic [NREQ-1:0]          pix_last,
  input  logic [NREQ*XW-1:0]       pix_x,
  input  logic [NREQ*YW-1:0]       pix_y,
  input  logic [NREQ*CW-1:0]       pix_color,
  output logic [NREQ-1:0]          gnt,
  output logic [XW-1:0]            vga_x,
  output logic [YW-1:0]            vga_y,
  output logic [CW-1:0]            vga_color,
  output logic                     vga_write,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic                     drop_err
);

  localparam int OW = $clog2(NREQ);
  localparam logic [WCW-1:0] STARVE_W = WCW'(STARVE_LIMIT);
  localparam logic [WCW-1:0] WAIT_MAX = {WCW{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [NREQ-1:0] gnt_r, gnt_nxt_s;
  logic [OW-1:0]   owner_r, owner_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic [WCW-1:0]  wait_r [NREQ];

  logic [XW-1:0]   vga_x_r;
  logic [YW-1:0]   vga_y_r;
  logic [CW-1:0]   vga_color_r;
  logic            vga_write_r;
  logic            drop_err_r;

  logic [OW-1:0]   norm_idx_s, st_idx_s, win_s;
  logic            norm_found_s, st_found_s;
  logic            accept_s, release_s, drop_s;

  // Winner selection: the lowest-index starved requester, else the lowest-index requester.
  always_comb begin
    norm_idx_s   = '0;
    norm_found_s = 1'b0;
    st_idx_s     = '0;
    st_found_s   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      norm_idx_s   = (req[i] && !norm_found_s) ? OW'(i) : norm_idx_s;
      norm_found_s = norm_found_s | req[i];
      st_idx_s     = (req[i] && (wait_r[i] >= STARVE_W) && !st_found_s) ? OW'(i) : st_idx_s;
      st_found_s   = st_found_s | (req[i] && (wait_r[i] >= STARVE_W));
    end
    win_s = st_found_s ? st_idx_s : norm_idx_s;
  end

  // A pixel is taken only from the current grantee; any other pixel is dropped.
  always_comb begin
    accept_s  = (state_r == ST_OWN) && pix_valid[owner_r] && gnt_r[owner_r];
    release_s = (state_r == ST_OWN) &&
                ((accept_s && pix_last[owner_r]) || !req[owner_r]);
    drop_s    = |(pix_valid & ~gnt_r);
  end

  // FSM next state: grant on the cycle after IDLE sees a request, release on last pixel or abort.
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt_r;
    owner_nxt_s = owner_r;
    busy_nxt_s  = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_nxt_s = ST_OWN;
          gnt_nxt_s   = NREQ'(1) << win_s;
          owner_nxt_s = win_s;
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = '0;
          busy_nxt_s  = 1'b0;
        end
      end
      ST_OWN: begin
        // Releasing always passes through IDLE, which gives the mandatory one-cycle gap.
        if (release_s) begin
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = '0;
          busy_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_OWN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = '0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // FSM and grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      gnt_r   <= '0;
      owner_r <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      gnt_r   <= gnt_nxt_s;
      owner_r <= owner_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Per-requester wait counters: count pending ungranted cycles, saturate, and clear on grant or idle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (reset || !req[i] || gnt_r[i]) begin
        wait_r[i] <= '0;
      end else if (wait_r[i] != WAIT_MAX) begin
        wait_r[i] <= wait_r[i] + WCW'(1);
      end
    end
  end

  // Registered VGA write port: coordinates hold between accepted pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_x_r     <= '0;
      vga_y_r     <= '0;
      vga_color_r <= '0;
      vga_write_r <= 1'b0;
    end else begin
      vga_write_r <= accept_s;
      if (accept_s) begin
        vga_x_r     <= pix_x[int'(owner_r)*XW +: XW];
        vga_y_r     <= pix_y[int'(owner_r)*YW +: YW];
        vga_color_r <= pix_color[int'(owner_r)*CW +: CW];
      end
    end
  end

  // Sticky drop error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_err_r <= 1'b0;
    end else if (drop_s) begin
      drop_err_r <= 1'b1;
    end
  end

  assign gnt       = gnt_r;
  assign owner     = owner_r;
  assign busy      = busy_r;
  assign vga_x     = vga_x_r;
  assign vga_y     = vga_y_r;
  assign vga_color = vga_color_r;
  assign vga_write = vga_write_r;
  assign drop_err  = drop_err_r;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Testbench for vga_write_arbiter. The directed scenarios come first and are
// followed by randomized burst traffic. A transaction-level model checks the
// outputs on every cycle. The model tracks "who holds the port" and "how long
// each engine has waited" in plain integers.
module tb_vga_write_arbiter;

  localparam int NREQ = 4;
  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int CW   = 9;
  localparam int LIM  = 8;
  localparam int WCW  = 4;
  localparam int WMAX = (1 << WCW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, pv, pl;
  logic [NREQ*XW-1:0] px;
  logic [NREQ*YW-1:0] py;
  logic [NREQ*CW-1:0] pc;
  logic [NREQ-1:0]   gnt;
  logic [XW-1:0]     vga_x;
  logic [YW-1:0]     vga_y;
  logic [CW-1:0]     vga_color;
  logic              vga_write;
  logic [1:0]        owner;
  logic              busy;
  logic              drop_err;

  vga_write_arbiter #(.NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW),
                      .STARVE_LIMIT(LIM), .WCW(WCW)) dut (
    .clk(clk), .reset(reset), .req(req), .pix_valid(pv), .pix_last(pl),
    .pix_x(px), .pix_y(py), .pix_color(pc), .gnt(gnt), .vga_x(vga_x),
    .vga_y(vga_y), .vga_color(vga_color), .vga_write(vga_write),
    .owner(owner), .busy(busy), .drop_err(drop_err));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state
  bit            m_busy;
  int            m_owner;
  bit            m_vw;
  bit            m_drop;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [CW-1:0] m_c;
  int            m_wait [NREQ];

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge. It uses the inputs that are stable at the edge.
  task automatic model_step();
    bit ob;
    int oo;
    bit acc;
    int win;
    ob = m_busy;
    oo = m_owner;
    if (reset) begin
      m_busy = 0; m_owner = 0; m_vw = 0; m_drop = 0;
      m_x = '0; m_y = '0; m_c = '0;
      for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
    end else begin
      acc = ob && pv[oo];
      m_vw = acc;
      if (acc) begin
        m_x = px[oo*XW +: XW];
        m_y = py[oo*YW +: YW];
        m_c = pc[oo*CW +: CW];
      end
      for (int i = 0; i < NREQ; i++)
        if (pv[i] && !(ob && oo == i)) m_drop = 1;
      if (ob) begin
        if ((acc && pl[oo]) || !req[oo]) m_busy = 0;
      end else if (req != 0) begin
        win = -1;
        for (int i = 0; i < NREQ; i++)
          if (win < 0 && req[i] && m_wait[i] >= LIM) win = i;
        for (int i = 0; i < NREQ; i++)
          if (win < 0 && req[i]) win = i;
        m_busy = 1;
        m_owner = win;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || (ob && oo == i)) m_wait[i] = 0;
        else if (m_wait[i] < WMAX) m_wait[i] = m_wait[i] + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_in();
    req = '0; pv = '0; pl = '0; px = '0; py = '0; pc = '0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("gnt", 32'(gnt), (m_busy ? 32'(4'b0001 << m_owner) : 32'd0));
      cmp("busy", 32'(busy), 32'(m_busy));
      cmp("vga_write", 32'(vga_write), 32'(m_vw));
      cmp("drop_err", 32'(drop_err), 32'(m_drop));
      cmp("vga_x", 32'(vga_x), 32'(m_x));
      cmp("vga_y", 32'(vga_y), 32'(m_y));
      cmp("vga_color", 32'(vga_color), 32'(m_c));
      if (m_busy) cmp("owner", 32'(owner), 32'(m_owner));
    end
  end

  bit act [NREQ];
  bit legal [NREQ];
  int blen [NREQ];
  int sent [NREQ];
  int cyc;

  initial begin
    clear_in();
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    cmp("lit_reset_gnt", 32'(gnt), 32'd0);
    cmp("lit_reset_busy", 32'(busy), 32'd0);
    cmp("lit_reset_vw", 32'(vga_write), 32'd0);
    reset = 1'b0;

    // Single burst from engine 2
    req = 4'b0100;
    step();
    cmp("lit_t1_gnt", 32'(gnt), 32'h4);
    pv[2] = 1'b1; px[20 +: 10] = 10'd5;
    step();
    cmp("lit_t1_x5", 32'(vga_x), 32'd5);
    px[20 +: 10] = 10'd6;
    step();
    px[20 +: 10] = 10'd7; pl[2] = 1'b1;
    step();
    cmp("lit_t1_x7", 32'(vga_x), 32'd7);
    cmp("lit_t1_vw", 32'(vga_write), 32'd1);
    cmp("lit_t1_rel", 32'(gnt), 32'd0);
    clear_in();
    step();
    cmp("lit_t1_vw_off", 32'(vga_write), 32'd0);

    // Fixed priority and the handover gap
    req = 4'b0110;
    step();
    cmp("lit_t2_gnt1", 32'(gnt), 32'h2);
    pv[1] = 1'b1; pl[1] = 1'b1;
    step();
    req = 4'b0100; pv = '0; pl = '0;
    cmp("lit_t2_gap", 32'(gnt), 32'd0);
    step();
    cmp("lit_t2_gnt2", 32'(gnt), 32'h4);
    req = 4'b0000;   // abort mid-burst
    step();
    cmp("lit_t5_abort", 32'(gnt), 32'd0);

    // No preemption
    req = 4'b1000;
    step();
    req = 4'b1001;
    step();
    cmp("lit_t3_keep", 32'(gnt), 32'h8);
    pv[3] = 1'b1; pl[3] = 1'b1;
    step();
    req = 4'b0001; pv = '0; pl = '0;
    step();
    cmp("lit_t3_gnt0", 32'(gnt), 32'h1);

    // Drop from a non-grantee, then reset mid-burst
    pv[1] = 1'b1; px[10 +: 10] = 10'd99;
    step();
    cmp("lit_t5_drop", 32'(drop_err), 32'd1);
    cmp("lit_t5_nowrite", 32'(vga_write), 32'd0);
    pv = '0;
    reset = 1'b1;
    step();
    cmp("lit_t6_gnt", 32'(gnt), 32'd0);
    cmp("lit_t6_drop", 32'(drop_err), 32'd0);
    reset = 1'b0;
    step();
    cmp("lit_t6_regrant", 32'(gnt), 32'h1);
    clear_in();
    step();
    step();

    // Starvation: engine 0 bursts back to back while engine 3 waits
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1001;
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      cyc++;
      if (gnt[3]) break;
      pv[0] = gnt[0];
      pl[0] = gnt[0];
    end
    cmp("lit_t4_starve_cycle", 32'(cyc), 32'd9);
    clear_in();
    step();
    step();

    // Randomized bursts
    for (int i = 0; i < NREQ; i++) begin act[i] = 0; legal[i] = 0; blen[i] = 0; sent[i] = 0; end
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pv[i] && legal[i]) begin
          sent[i]++;
          if (pl[i]) act[i] = 0;
        end
        pv[i] = 1'b0; pl[i] = 1'b0; legal[i] = 0;
        if (act[i] && $urandom_range(0, 31) == 0) act[i] = 0;
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i] = 1; blen[i] = $urandom_range(1, 4); sent[i] = 0;
        end
        req[i] = act[i];
        if (act[i] && gnt[i] && $urandom_range(0, 3) != 0) begin
          pv[i] = 1'b1; legal[i] = 1;
          pl[i] = (sent[i] == blen[i] - 1);
        end else if ($urandom_range(0, 63) == 0) begin
          pv[i] = 1'b1; pl[i] = 1'($urandom_range(0, 1));
        end
        px[i*XW +: XW] = XW'($urandom);
        py[i*YW +: YW] = YW'($urandom);
        pc[i*CW +: CW] = CW'($urandom);
      end
      reset = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
